// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter for the 6502 bus.
// Bytes written to BASE_ADDR are queued in a small FIFO and shifted out
// LSB first; BASE_ADDR+1 is a read-only status register whose overflow
// flag can be cleared by writing 1 to bit 2.
module uart_tx_port #(
   parameter int          CLKS_PER_BIT = 16,
   parameter int          FIFO_DEPTH   = 4,
   parameter logic [15:0] BASE_ADDR    = 16'hF010
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] address,
   input  logic        write_en,
   input  logic [7:0]  data_in,
   output logic [7:0]  data_out,
   output logic        sel,
   output logic        tx
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   localparam logic [CW-1:0] CLK_LAST    = CW'(CLKS_PER_BIT - 1);
   localparam logic [PW-1:0] PTR_LAST    = PW'(FIFO_DEPTH - 1);
   localparam logic [2:0]    DEPTH_C     = 3'(FIFO_DEPTH);
   localparam logic [15:0]   STATUS_ADDR = BASE_ADDR + 16'd1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic [7:0]      shift_q, shift_d;
   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [2:0]      count_q, count_d;
   logic            overflow_q, overflow_d;

   logic            push_req;
   logic            push_acc;
   logic            pop;
   logic            drop;
   logic            ovf_clr;
   logic            clk_last;
   logic [7:0]      status;

   // Bus decode: a push may use the slot freed by a pop at the same edge.
   always_comb begin
      push_req = write_en && (address == BASE_ADDR);
      pop      = (state_q == S_IDLE) && (count_q != 3'd0);
      push_acc = push_req && ((count_q < DEPTH_C) || pop);
      drop     = push_req && !push_acc;
      ovf_clr  = write_en && (address == STATUS_ADDR) && data_in[2];
   end

   // FIFO bookkeeping and sticky overflow; a drop at the same edge beats a clear.
   always_comb begin
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      end
      if (push_acc) begin
         wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      end
      case ({push_acc, pop})
         2'b10:   count_d = count_q + 3'd1;
         2'b01:   count_d = count_q - 3'd1;
         default: count_d = count_q;
      endcase
      if (drop) begin
         overflow_d = 1'b1;
      end else if (ovf_clr) begin
         overflow_d = 1'b0;
      end
   end

   // FIFO storage write port.
   // NOTE: the data array has no reset; the pointers and count alone decide
   // which entries are valid, so clearing the storage would buy nothing.
   always_ff @(posedge clock) begin
      if (push_acc) begin
         mem_q[wr_ptr_q] <= data_in;
      end
   end

   // Transmit FSM next state: each of START, 8 DATA bits and STOP lasts CLKS_PER_BIT cycles.
   always_comb begin
      state_d   = state_q;
      clk_cnt_d = clk_cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      clk_last  = (clk_cnt_q == CLK_LAST);
      case (state_q)
         S_IDLE: begin
            if (pop) begin
               state_d   = S_START;
               clk_cnt_d = '0;
               shift_d   = mem_q[rd_ptr_q];
            end
         end
         S_START: begin
            if (clk_last) begin
               state_d   = S_DATA;
               clk_cnt_d = '0;
               bit_idx_d = 3'd0;
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         S_DATA: begin
            if (clk_last) begin
               clk_cnt_d = '0;
               shift_d   = {1'b0, shift_q[7:1]};
               if (bit_idx_q == 3'd7) begin
                  state_d = S_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         S_STOP: begin
            if (clk_last) begin
               state_d   = S_IDLE;
               clk_cnt_d = '0;
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d   = S_IDLE;
            clk_cnt_d = '0;
         end
      endcase
   end

   // State registers with synchronous reset; a reset mid-frame abandons the frame.
   // NOTE: non-blocking assignments here so every register samples the
   // pre-edge value of the others, independent of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_IDLE;
         clk_cnt_q  <= '0;
         bit_idx_q  <= 3'd0;
         shift_q    <= 8'h00;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= 3'd0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         clk_cnt_q  <= clk_cnt_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Serial line level and status read mux, both decoded from registered state.
   always_comb begin
      case (state_q)
         S_START: tx = 1'b0;
         S_DATA:  tx = shift_q[0];
         default: tx = 1'b1;
      endcase
      status = {1'b0, count_q, 1'b0, overflow_q,
                (count_q == 3'd0) && (state_q == S_IDLE),
                count_q < DEPTH_C};
      sel      = (address == STATUS_ADDR) && !write_en;
      data_out = sel ? status : 8'h00;
   end

endmodule
